// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers shared by the sequential scheduler
// and the encrypt datapath's PC-2 stage.
package des_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Tables use 1-based DES bit numbering; bit 1 is the MSB of each vector.
    localparam int unsigned PC1_C [1:28] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36
    };

    localparam int unsigned PC1_D [1:28] = '{
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_SCHED [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [27:0] pc1_c(input logic [63:0] key);
        logic [27:0] c;
        c = '0;
        for (int unsigned i = 1; i <= 28; i++) begin
            c[5'(28 - i)] = key[6'(64 - PC1_C[i])];
        end
        return c;
    endfunction

    function automatic logic [27:0] pc1_d(input logic [63:0] key);
        logic [27:0] d;
        d = '0;
        for (int unsigned i = 1; i <= 28; i++) begin
            d[5'(28 - i)] = key[6'(64 - PC1_D[i])];
        end
        return d;
    endfunction

    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] k;
        cd = {c, d};
        k  = '0;
        for (int unsigned i = 1; i <= 48; i++) begin
            k[6'(48 - i)] = cd[6'(56 - PC2[i])];
        end
        return k;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] y;
        case (n)
            2'd1:    y = {x[26:0], x[27]};
            2'd2:    y = {x[25:0], x[27:26]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] y;
        case (n)
            2'd1:    y = {x[0], x[27:1]};
            2'd2:    y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    // Out-of-range rounds yield 0 so the rotator passes its input through.
    function automatic logic [1:0] shift_amount(input logic [4:0] rnd);
        logic [1:0] amt;
        amt = 2'd0;
        if (rnd >= 5'd1 && rnd <= 5'd16) begin
            amt = SHIFT_SCHED[rnd];
        end
        return amt;
    endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// 28-bit circular rotate of one C or D half; dir_i=0 rotates left, 1 rotates right.
module des_cd_rotator
    import des_pkg::*;
(
    input  logic [27:0] x_i,
    input  logic        dir_i,
    input  logic [1:0]  amt_i,
    output logic [27:0] y_o
);

    always_comb begin
        y_o = x_i;
        if (dir_i) begin
            y_o = ror28(x_i, amt_i);
        end else begin
            y_o = rol28(x_i, amt_i);
        end
    end

endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES subkey scheduler: one 48-bit subkey per valid/ready beat,
// K1..K16 for encrypt or K16..K1 for decrypt.
module des_key_scheduler
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        start,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [4:0]  round,
    output logic        last
);

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [27:0] c_rot, d_rot;
    logic [4:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic [1:0]  rot_amt;
    logic        run;
    logic        handshake;
    logic        is_last;

    assign run       = (state_q == ST_RUN);
    assign handshake = run && subkey_ready;
    assign is_last   = run && (dec_q ? (round_q == 5'd1) : (round_q == 5'd16));

    // Encrypt moves to the next round's shift; decrypt undoes the current round's shift.
    assign rot_amt = dec_q ? shift_amount(round_q) : shift_amount(round_q + 5'd1);

    des_cd_rotator u_rot_c (
        .x_i   (c_q),
        .dir_i (dec_q),
        .amt_i (rot_amt),
        .y_o   (c_rot)
    );

    des_cd_rotator u_rot_d (
        .x_i   (d_q),
        .dir_i (dec_q),
        .amt_i (rot_amt),
        .y_o   (d_rot)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    dec_d   = decrypt;
                    if (decrypt) begin
                        c_d     = pc1_c(key);
                        d_d     = pc1_d(key);
                        round_d = 5'd16;
                    end else begin
                        c_d     = rol28(pc1_c(key), 2'd1);
                        d_d     = rol28(pc1_d(key), 2'd1);
                        round_d = 5'd1;
                    end
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        c_d     = c_rot;
                        d_d     = d_rot;
                        round_d = dec_q ? (round_q - 5'd1) : (round_q + 5'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    assign busy         = run;
    assign subkey_valid = run;
    assign subkey       = pc2(c_q, d_q);
    assign round        = round_q;
    assign last         = is_last;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Scoreboard bench for des_key_scheduler using the classic 0x133457799BBCDFF1 key.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key;
    logic        decrypt;
    logic        start;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [4:0]  round;
    logic        last;

    always #5 clk = ~clk;

    des_key_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .decrypt      (decrypt),
        .start        (start),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round        (round),
        .last         (last)
    );

    localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
    localparam logic [63:0] PARITY = 64'h0101010101010101;

    // Hand-computed subkeys K1..K16 for KEY.
    localparam logic [47:0] KS [1:16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct packed {
        logic [4:0]  rnd;
        logic [47:0] k;
        logic        l;
    } beat_t;

    beat_t sb[$];
    int    checks    = 0;
    int    failures  = 0;
    int    hs_count  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected beats 1..n of a schedule.
    task automatic push_sched(input logic dec, input int n);
        beat_t b;
        for (int i = 1; i <= n; i++) begin
            b.rnd = dec ? 5'(17 - i) : 5'(i);
            b.k   = KS[b.rnd];
            b.l   = (i == 16);
            sb.push_back(b);
        end
    endtask

    task automatic start_sched(input logic [63:0] k, input logic dec);
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget, input logic random_ready);
        int n;
        n = 0;
        while (hs_count < target && n < budget) begin
            if (random_ready) subkey_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        subkey_ready = 1'b1;
        checks++;
        if (hs_count < target) begin
            failures++;
            $display("FAIL handshake_timeout actual=%0d required=%0d", hs_count, target);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [47:0] prev_k;
    logic [4:0]  prev_r;
    logic        prev_l;

    always @(negedge clk) begin
        beat_t e;
        if (prev_stall) begin
            check("hold_valid",  64'(subkey_valid), 64'd1);
            check("hold_subkey", 64'(subkey), 64'(prev_k));
            check("hold_round",  64'(round), 64'(prev_r));
            check("hold_last",   64'(last), 64'(prev_l));
        end
        if (subkey_valid === 1'b1 && subkey_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=round %0d subkey %h required=no beat", round, subkey);
            end else begin
                e = sb.pop_front();
                check("beat_round",  64'(round), 64'(e.rnd));
                check("beat_subkey", 64'(subkey), 64'(e.k));
                check("beat_last",   64'(last), 64'(e.l));
            end
            hs_count++;
        end
        prev_stall = (subkey_valid === 1'b1) && (subkey_ready === 1'b0);
        prev_k     = subkey;
        prev_r     = round;
        prev_l     = last;
    end

    initial begin
        rst          = 1'b1;
        key          = '0;
        decrypt      = 1'b0;
        start        = 1'b0;
        subkey_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_valid",  64'(subkey_valid), 64'd0);
        check("rst_round",  64'(round), 64'd0);
        check("rst_last",   64'(last), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Encrypt at full rate; a start held over the last handshake is ignored then accepted.
        push_sched(1'b0, 16);
        start_sched(KEY, 1'b0);
        check("enc_busy",   64'(busy), 64'd1);
        check("enc_round1", 64'(round), 64'd1);
        repeat (15) begin @(posedge clk); #1; end
        check("enc_last16", 64'(last), 64'd1);
        push_sched(1'b1, 16);
        key     = KEY;
        decrypt = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        check("end_busy",  64'(busy), 64'd0);
        check("end_valid", 64'(subkey_valid), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_busy",  64'(busy), 64'd1);
        check("restart_round", 64'(round), 64'd16);

        // Decrypt with a stray start (other key, encrypt) at beat 5.
        repeat (4) begin @(posedge clk); #1; end
        key     = 64'h0123456789ABCDEF;
        decrypt = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        key     = KEY;
        decrypt = 1'b1;
        wait_hs(32, 40, 1'b0);
        check("dec_done_busy", 64'(busy), 64'd0);

        // Parity bits flipped.
        push_sched(1'b0, 16);
        start_sched(KEY ^ PARITY, 1'b0);
        wait_hs(48, 40, 1'b0);

        // Random back-pressure, both directions.
        push_sched(1'b0, 16);
        start_sched(KEY, 1'b0);
        wait_hs(64, 600, 1'b1);
        @(posedge clk); #1;
        push_sched(1'b1, 16);
        start_sched(KEY, 1'b1);
        wait_hs(80, 600, 1'b1);
        @(posedge clk); #1;

        // Reset at beat 7, then a fresh schedule.
        push_sched(1'b0, 7);
        start_sched(KEY, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        check("pre_rst_round", 64'(round), 64'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy",   64'(busy), 64'd0);
        check("mid_rst_valid",  64'(subkey_valid), 64'd0);
        check("mid_rst_round",  64'(round), 64'd0);
        check("mid_rst_subkey", 64'(subkey), 64'd0);
        push_sched(1'b0, 16);
        start_sched(KEY, 1'b0);
        check("post_rst_subkey", 64'(subkey), 64'(KS[1]));
        wait_hs(103, 40, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
